// File: rtl/sram_arbiter_if.sv
// Bundle of loader, CPU and SRAM-pad signals shared by the SRAM arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface sram_arbiter_if #(
    parameter int ADR_WIDTH = 21
);
    logic [ADR_WIDTH-1:0] ld_adr;
    logic [7:0]           ld_data;
    logic                 ld_write;
    logic                 ld_overrun;
    logic                 cpu_req;
    logic                 cpu_we;
    logic [ADR_WIDTH-1:0] cpu_adr;
    logic [7:0]           cpu_wdata;
    logic [7:0]           cpu_rdata;
    logic                 cpu_ack;
    logic [ADR_WIDTH-1:0] sram_adr;
    logic [7:0]           sram_dq_out;
    logic                 sram_dq_oe;
    logic [7:0]           sram_dq_in;
    logic                 sram_ce_n;
    logic                 sram_oe_n;
    logic                 sram_we_n;
    logic                 busy;

    modport slave (
        input  ld_adr, ld_data, ld_write, cpu_req, cpu_we, cpu_adr, cpu_wdata, sram_dq_in,
        output ld_overrun, cpu_rdata, cpu_ack, sram_adr, sram_dq_out, sram_dq_oe,
               sram_ce_n, sram_oe_n, sram_we_n, busy
    );

    modport master (
        output ld_adr, ld_data, ld_write, cpu_req, cpu_we, cpu_adr, cpu_wdata, sram_dq_in,
        input  ld_overrun, cpu_rdata, cpu_ack, sram_adr, sram_dq_out, sram_dq_oe,
               sram_ce_n, sram_oe_n, sram_we_n, busy
    );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin sharing of a byte-wide async SRAM between a 1-entry loader write buffer
// and a held-request CPU port, with fixed setup/strobe/hold strobe sequencing.
module sram_arbiter #(
    parameter int ADR_WIDTH = 21
) (
    input  logic          clk,
    input  logic          reset_n,
    sram_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_W_SETUP,
        S_W_STRB,
        S_W_HOLD,
        S_R_SETUP,
        S_R_SMPL
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_grant_ld;
    logic                 w_grant_cpu;

    logic                 r_ld_pend;
    logic                 r_ld_overrun;
    logic [ADR_WIDTH-1:0] r_ld_adr;
    logic [7:0]           r_ld_data;
    logic                 r_last_ld;

    logic [ADR_WIDTH-1:0] r_acc_adr;
    logic [7:0]           r_acc_data;
    logic                 r_acc_cpu;
    logic [7:0]           r_rdata;

    logic                 r_ce_n;
    logic                 r_oe_n;
    logic                 r_we_n;
    logic                 r_dq_oe;
    logic                 r_ack;
    logic                 r_busy;

    always_comb begin
        w_state_next = r_state;
        w_grant_ld   = 1'b0;
        w_grant_cpu  = 1'b0;
        case (r_state)
            S_IDLE: begin
                // With both sides pending, the loader goes only if the CPU had the last turn.
                if (r_ld_pend && !(bus.cpu_req && r_last_ld)) begin
                    w_grant_ld   = 1'b1;
                    w_state_next = S_W_SETUP;
                end else if (bus.cpu_req) begin
                    w_grant_cpu  = 1'b1;
                    w_state_next = bus.cpu_we ? S_W_SETUP : S_R_SETUP;
                end
            end
            S_W_SETUP: w_state_next = S_W_STRB;
            S_W_STRB:  w_state_next = S_W_HOLD;
            S_W_HOLD:  w_state_next = S_IDLE;
            S_R_SETUP: w_state_next = S_R_SMPL;
            S_R_SMPL:  w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_ld_pend    <= 1'b0;
            r_ld_overrun <= 1'b0;
            r_ld_adr     <= '0;
            r_ld_data    <= '0;
            r_last_ld    <= 1'b0;
            r_acc_adr    <= '0;
            r_acc_data   <= '0;
            r_acc_cpu    <= 1'b0;
            r_rdata      <= '0;
            r_ce_n       <= 1'b1;
            r_oe_n       <= 1'b1;
            r_we_n       <= 1'b1;
            r_dq_oe      <= 1'b0;
            r_ack        <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state <= w_state_next;

            // Pad strobes are registered from the next state so they change cleanly on the edge.
            r_ce_n  <= (w_state_next == S_IDLE);
            r_we_n  <= (w_state_next != S_W_STRB);
            r_oe_n  <= !(w_state_next == S_R_SETUP || w_state_next == S_R_SMPL);
            r_dq_oe <= (w_state_next == S_W_SETUP || w_state_next == S_W_STRB ||
                        w_state_next == S_W_HOLD);
            r_busy  <= (w_state_next != S_IDLE);
            r_ack   <= r_acc_cpu && (w_state_next == S_W_HOLD || w_state_next == S_R_SMPL);

            // Capture at the end of R_SETUP so cpu_rdata is already valid during the ack cycle.
            if (r_state == S_R_SETUP) begin
                r_rdata <= bus.sram_dq_in;
            end

            if (w_grant_ld) begin
                r_acc_adr  <= r_ld_adr;
                r_acc_data <= r_ld_data;
                r_acc_cpu  <= 1'b0;
                r_last_ld  <= 1'b1;
            end else if (w_grant_cpu) begin
                r_acc_adr  <= bus.cpu_adr;
                r_acc_data <= bus.cpu_wdata;
                r_acc_cpu  <= 1'b1;
                r_last_ld  <= 1'b0;
            end

            if (bus.ld_write) begin
                if (!r_ld_pend || w_grant_ld) begin
                    r_ld_pend <= 1'b1;
                    r_ld_adr  <= bus.ld_adr;
                    r_ld_data <= bus.ld_data;
                end else begin
                    r_ld_overrun <= 1'b1;
                end
            end else if (w_grant_ld) begin
                r_ld_pend <= 1'b0;
            end
        end
    end

    assign bus.ld_overrun  = r_ld_overrun;
    assign bus.cpu_rdata   = r_rdata;
    assign bus.cpu_ack     = r_ack;
    assign bus.sram_adr    = r_acc_adr;
    assign bus.sram_dq_out = r_acc_data;
    assign bus.sram_dq_oe  = r_dq_oe;
    assign bus.sram_ce_n   = r_ce_n;
    assign bus.sram_oe_n   = r_oe_n;
    assign bus.sram_we_n   = r_we_n;
    assign bus.busy        = r_busy;
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus random traffic, checked every cycle
// against an access-position model of the arbiter.
module tb_sram_arbiter;
    localparam int AW = 21;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_fail;

    sram_arbiter_if #(.ADR_WIDTH(AW)) bus ();

    sram_arbiter #(.ADR_WIDTH(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an access is a numbered sequence of cycles (write 3, read 2);
    // strobes, ack and sampling follow from the position within the access.
    int          m_pos;
    int          m_len;
    bit          m_wr;
    bit          m_cpu;
    bit          m_last_ld;
    bit          m_pend;
    bit          m_ovr;
    bit          m_freed;
    logic [AW-1:0] m_adr;
    logic [AW-1:0] m_ld_adr;
    logic [7:0]  m_data;
    logic [7:0]  m_ld_data;
    logic [7:0]  m_rdata;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pos = -1; m_len = 0; m_wr = 0; m_cpu = 0; m_last_ld = 0;
            m_pend = 0; m_ovr = 0; m_adr = '0; m_data = '0; m_rdata = '0;
            m_ld_adr = '0; m_ld_data = '0;
        end else begin
            m_freed = 0;
            if (m_pos < 0) begin
                if (m_pend && !(bus.cpu_req && m_last_ld)) begin
                    m_adr = m_ld_adr; m_data = m_ld_data; m_wr = 1; m_cpu = 0;
                    m_len = 3; m_pos = 0; m_last_ld = 1; m_freed = 1;
                end else if (bus.cpu_req) begin
                    m_adr = bus.cpu_adr; m_data = bus.cpu_wdata; m_wr = bus.cpu_we; m_cpu = 1;
                    m_len = bus.cpu_we ? 3 : 2; m_pos = 0; m_last_ld = 0;
                end
            end else begin
                if (!m_wr && m_pos == 0) m_rdata = bus.sram_dq_in;
                m_pos = m_pos + 1;
                if (m_pos == m_len) m_pos = -1;
            end
            if (bus.ld_write) begin
                if (!m_pend || m_freed) begin
                    m_pend = 1; m_ld_adr = bus.ld_adr; m_ld_data = bus.ld_data;
                end else begin
                    m_ovr = 1;
                end
            end else if (m_freed) begin
                m_pend = 0;
            end
        end
    end

    // Cycle checker against the model
    always @(posedge clk) begin
        logic [6:0] e_ctl;
        logic [6:0] a_ctl;
        bit e_busy;
        #2;
        if (reset_n) begin
            e_busy = (m_pos >= 0);
            e_ctl  = {!e_busy, !(e_busy && !m_wr), !(e_busy && m_wr && m_pos == 1),
                      e_busy && m_wr, e_busy && m_cpu && (m_pos == m_len - 1), e_busy, m_ovr};
            a_ctl  = {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_dq_oe,
                      bus.cpu_ack, bus.busy, bus.ld_overrun};
            n_cmp++;
            if (a_ctl !== e_ctl || bus.sram_adr !== m_adr || bus.sram_dq_out !== m_data ||
                bus.cpu_rdata !== m_rdata) begin
                n_fail++;
                $display("FAIL cycle t=%0t: ce/oe/we/oe_dq/ack/busy/ovr=%b adr=%h dq=%h rdata=%h, want %b adr=%h dq=%h rdata=%h",
                         $time, a_ctl, bus.sram_adr, bus.sram_dq_out, bus.cpu_rdata,
                         e_ctl, m_adr, m_data, m_rdata);
            end
        end
    end

    task automatic idle_inputs();
        bus.ld_write = 0; bus.ld_adr = '0; bus.ld_data = '0;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_adr = '0; bus.cpu_wdata = '0;
        bus.sram_dq_in = '0;
    endtask

    task automatic pulse_reset();
        @(negedge clk); reset_n = 0;
        @(negedge clk); reset_n = 1;
    endtask

    task automatic test_reset();
        int guard;
        bit bad;
        idle_inputs();
        reset_n = 0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_dq_oe, bus.cpu_ack, bus.busy,
             bus.ld_overrun} !== 7'b1110000 || bus.sram_adr !== '0 || bus.sram_dq_out !== 8'h00 ||
            bus.cpu_rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_state: ctl=%b adr=%h dq=%h rdata=%h, want 1110000 0 0 0",
                     {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_dq_oe, bus.cpu_ack,
                      bus.busy, bus.ld_overrun}, bus.sram_adr, bus.sram_dq_out, bus.cpu_rdata);
        end
        reset_n = 1;
        @(negedge clk);
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_adr = 21'h000040; bus.cpu_wdata = 8'h77;
        guard = 0;
        while (bus.sram_we_n !== 1'b0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (guard >= 10) begin
            n_fail++;
            $display("FAIL reset_reach_strobe: we_n=%b after %0d clk, want 0", bus.sram_we_n, guard);
        end
        #1 reset_n = 0;
        bus.cpu_req = 0;
        #1;
        n_cmp++;
        if ({bus.sram_we_n, bus.sram_ce_n, bus.sram_dq_oe} !== 3'b110) begin
            n_fail++;
            $display("FAIL reset_async_release: we_n/ce_n/dq_oe=%b, want 110",
                     {bus.sram_we_n, bus.sram_ce_n, bus.sram_dq_oe});
        end
        @(negedge clk); reset_n = 1;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.cpu_ack !== 1'b0) bad = 1;
        end
        n_cmp++;
        if (bad) begin
            n_fail++;
            $display("FAIL reset_after: busy/ack seen=%0d, want 0", bad);
        end
        $display("test_reset done");
    endtask

    task automatic test_loader_byte();
        int we_cycles;
        bit saw_ack;
        @(negedge clk);
        bus.ld_adr = 21'h00010; bus.ld_data = 8'hA5; bus.ld_write = 1;
        @(negedge clk);
        bus.ld_write = 0;
        we_cycles = 0; saw_ack = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.cpu_ack) saw_ack = 1;
            if (bus.sram_we_n === 1'b0) begin
                we_cycles++;
                n_cmp++;
                if (bus.sram_adr !== 21'h00010 || bus.sram_dq_out !== 8'hA5 ||
                    bus.sram_dq_oe !== 1'b1 || bus.sram_ce_n !== 1'b0) begin
                    n_fail++;
                    $display("FAIL loader_strobe: adr=%h dq=%h oe=%b ce_n=%b, want 00010 a5 1 0",
                             bus.sram_adr, bus.sram_dq_out, bus.sram_dq_oe, bus.sram_ce_n);
                end
            end
        end
        n_cmp++;
        if (we_cycles != 1 || saw_ack) begin
            n_fail++;
            $display("FAIL loader_we_width: we_n low %0d clk ack=%0d, want 1 clk ack=0", we_cycles, saw_ack);
        end
        $display("test_loader_byte: adr=00010 data=a5 we_cycles=%0d", we_cycles);
    endtask

    task automatic test_cpu_read();
        int k;
        int oe_low;
        bit got;
        @(negedge clk);
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_adr = 21'h1FFFFF; bus.sram_dq_in = 8'h3C;
        k = 0; oe_low = 0; got = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            k++;
            if (bus.sram_oe_n === 1'b0) oe_low++;
            if (bus.cpu_ack === 1'b1 && !got) begin
                got = 1;
                n_cmp++;
                if (k != 2 || bus.cpu_rdata !== 8'h3C || bus.sram_adr !== 21'h1FFFFF) begin
                    n_fail++;
                    $display("FAIL cpu_read_ack: ack at %0d clk rdata=%h adr=%h, want 2 3c 1fffff",
                             k, bus.cpu_rdata, bus.sram_adr);
                end
                bus.cpu_req = 0;
                bus.sram_dq_in = 8'hC3;
            end
        end
        n_cmp++;
        if (!got || oe_low != 2 || bus.cpu_rdata !== 8'h3C) begin
            n_fail++;
            $display("FAIL cpu_read_done: ack=%0d oe_low=%0d rdata=%h, want 1 2 3c", got, oe_low, bus.cpu_rdata);
        end
        $display("test_cpu_read: adr=1fffff rdata=%h oe_low=%0d", bus.cpu_rdata, oe_low);
    endtask

    task automatic test_round_robin();
        bit grants[$];
        bit prev_busy;
        int guard;
        pulse_reset();
        @(negedge clk);
        bus.ld_adr = 21'h0AAAA; bus.ld_data = 8'h11; bus.ld_write = 1;
        @(negedge clk);
        bus.ld_write = 0;
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_adr = 21'h15555; bus.cpu_wdata = 8'h22;
        prev_busy = 0; guard = 0;
        while (grants.size() < 8 && guard < 80) begin
            @(negedge clk);
            guard++;
            bus.ld_write = 0;
            if (bus.busy && !prev_busy) begin
                grants.push_back(bus.sram_adr == 21'h0AAAA);
                if (bus.sram_adr == 21'h0AAAA) bus.ld_write = 1;
            end
            prev_busy = bus.busy;
        end
        guard = 0;
        @(negedge clk);
        bus.ld_write = 0;
        while (bus.cpu_ack !== 1'b1 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        bus.cpu_req = 0;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (grants.size() != 8) begin
            n_fail++;
            $display("FAIL rr_count: %0d grants, want 8", grants.size());
        end
        foreach (grants[i]) begin
            n_cmp++;
            if (grants[i] != (i % 2 == 0)) begin
                n_fail++;
                $display("FAIL rr_order: grant %0d loader=%0d, want %0d", i, grants[i], (i % 2 == 0));
            end
            $display("rr grant %0d: %s", i, grants[i] ? "LOADER" : "CPU");
        end
        n_cmp++;
        if (bus.ld_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_overrun: ld_overrun=%b, want 0", bus.ld_overrun);
        end
    endtask

    task automatic test_loader_with_cpu();
        logic [AW+7:0] exp_q[$];
        logic [AW+7:0] e;
        int sent;
        int seen;
        int guard;
        sent = 0; seen = 0;
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_adr = 21'h000123; bus.cpu_wdata = 8'h5E;
        for (int cyc = 0; cyc < 72; cyc++) begin
            @(negedge clk);
            bus.ld_write = 0;
            if (cyc % 8 == 0 && sent < 6) begin
                bus.ld_adr = AW'(21'h100000 + sent); bus.ld_data = 8'($urandom);
                bus.ld_write = 1;
                exp_q.push_back({bus.ld_adr, bus.ld_data});
                sent++;
            end
            if (bus.sram_we_n === 1'b0 && bus.sram_adr[AW-1]) begin
                seen++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                n_cmp++;
                if ({bus.sram_adr, bus.sram_dq_out} !== e) begin
                    n_fail++;
                    $display("FAIL stream_byte: wrote adr=%h dq=%h, want adr=%h dq=%h",
                             bus.sram_adr, bus.sram_dq_out, e[AW+7:8], e[7:0]);
                end
                $display("stream loader byte adr=%h dq=%h", bus.sram_adr, bus.sram_dq_out);
            end
        end
        guard = 0;
        while (bus.cpu_ack !== 1'b1 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        bus.cpu_req = 0;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (seen != 6 || bus.ld_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_total: %0d loader bytes overrun=%b, want 6 0", seen, bus.ld_overrun);
        end
    endtask

    task automatic test_overrun();
        int guard;
        bit saw_first;
        bit saw_second;
        @(negedge clk);
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_adr = 21'h000200; bus.cpu_wdata = 8'h99;
        guard = 0;
        while (bus.busy !== 1'b1 && guard < 6) begin
            @(negedge clk);
            guard++;
        end
        bus.ld_adr = 21'h000301; bus.ld_data = 8'hD1; bus.ld_write = 1;
        @(negedge clk);
        bus.ld_adr = 21'h000302; bus.ld_data = 8'hD2; bus.ld_write = 1;
        saw_first = 0; saw_second = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            bus.ld_write = 0;
            if (bus.cpu_ack === 1'b1) bus.cpu_req = 0;
            if (bus.sram_we_n === 1'b0 && bus.sram_adr == 21'h000301 && bus.sram_dq_out == 8'hD1)
                saw_first = 1;
            if (bus.sram_we_n === 1'b0 && bus.sram_adr == 21'h000302) saw_second = 1;
        end
        n_cmp++;
        if (!saw_first || saw_second || bus.ld_overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun: first=%0d second=%0d ld_overrun=%b, want 1 0 1",
                     saw_first, saw_second, bus.ld_overrun);
        end
        $display("test_overrun: first=%0d second=%0d ld_overrun=%b", saw_first, saw_second, bus.ld_overrun);
    endtask

    task automatic test_random();
        int guard;
        pulse_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            bus.sram_dq_in = 8'($urandom);
            bus.ld_write = ($urandom_range(0, 5) == 0);
            if (bus.ld_write) begin
                bus.ld_adr = AW'($urandom); bus.ld_data = 8'($urandom);
            end
            if (bus.cpu_req && bus.cpu_ack) begin
                if ($urandom_range(0, 1) == 0) bus.cpu_req = 0;
            end else if (!bus.cpu_req && $urandom_range(0, 3) == 0) begin
                bus.cpu_req = 1; bus.cpu_we = 1'($urandom);
                bus.cpu_adr = AW'($urandom); bus.cpu_wdata = 8'($urandom);
            end
        end
        bus.ld_write = 0;
        guard = 0;
        while (bus.cpu_req && bus.cpu_ack !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        bus.cpu_req = 0;
        repeat (10) @(negedge clk);
        $display("test_random: 1500 cycles done, overrun=%b", bus.ld_overrun);
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        reset_n = 0;
        idle_inputs();
        test_reset();
        test_loader_byte();
        test_cpu_read();
        test_round_robin();
        test_loader_with_cpu();
        test_overrun();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
